// File: rtl/peak_meter_pkg.sv
// Shared metering definitions: magnitude width derivation, saturating magnitude,
// and the hold/decay state encoding used by per-channel peak logic.
package peak_meter_pkg;

  typedef enum logic [0:0] {
    StHold  = 1'b0,
    StDecay = 1'b1
  } hold_state_e;

  function automatic int unsigned mag_width(input int unsigned data_w, input bit signed_in);
    return signed_in ? data_w - 1 : data_w;
  endfunction

  // Magnitude of the low data_w bits of x; the most-negative code saturates to full scale.
  function automatic logic [31:0] mag_sat(input logic [31:0] x, input int unsigned data_w,
                                          input bit signed_in);
    logic [31:0] mask_d;
    logic [31:0] mask_m;
    logic [31:0] neg;
    mask_d = (data_w >= 32) ? 32'hffff_ffff : ((32'd1 << data_w) - 32'd1);
    if (!signed_in) return x & mask_d;
    mask_m = mask_d >> 1;
    if (((x >> (data_w - 1)) & 32'd1) == 32'd0) return x & mask_m;
    neg = (~x + 32'd1) & mask_d;
    return (neg > mask_m) ? mask_m : neg;
  endfunction

endpackage

// File: rtl/peak_meter_chan.sv
// One metering channel: sample magnitude, window max accumulator, peak-hold/decay
// state machine and the registered display outputs.
module peak_meter_chan
  import peak_meter_pkg::*;
#(
  parameter int unsigned DataW       = 16,
  parameter int unsigned HoldWindows = 4,
  parameter int unsigned DecayStep   = 1,
  parameter bit          SignedIn    = 1'b1,
  localparam int unsigned MagW       = mag_width(DataW, SignedIn)
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             valid_i,
  input  logic             final_i,
  input  logic [DataW-1:0] din_i,
  output logic [MagW-1:0]  peak_o,
  output logic [MagW-1:0]  win_max_o,
  output logic             clip_o
);

  localparam int unsigned HoldW = (HoldWindows > 0) ? $clog2(HoldWindows + 1) : 1;
  localparam logic [HoldW-1:0] HoldReload = HoldW'(HoldWindows);

  hold_state_e      state_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic [MagW-1:0]  acc_q, peak_q, win_max_q;
  logic             clip_q;

  logic [MagW-1:0]  mag, result, decay_floor;
  logic [MagW:0]    decay_diff;

  assign mag         = MagW'(mag_sat(32'(din_i), DataW, SignedIn));
  assign result      = (mag > acc_q) ? mag : acc_q;
  assign decay_diff  = {1'b0, peak_q} - (MagW + 1)'(DecayStep);
  // Borrow out of the subtraction means the decay would wrap: clamp at zero.
  assign decay_floor = decay_diff[MagW] ? '0 : decay_diff[MagW-1:0];

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q    <= StHold;
      hold_cnt_q <= '0;
      acc_q      <= '0;
      peak_q     <= '0;
      win_max_q  <= '0;
      clip_q     <= 1'b0;
    end else if (clear_i) begin
      state_q    <= StHold;
      hold_cnt_q <= '0;
      acc_q      <= '0;
      peak_q     <= '0;
      win_max_q  <= '0;
      clip_q     <= 1'b0;
    end else if (valid_i) begin
      if (!final_i) begin
        acc_q <= result;
      end else begin
        acc_q     <= '0;
        win_max_q <= result;
        clip_q    <= &result;
        case (state_q)
          StHold: begin
            if (result >= peak_q) begin
              peak_q     <= result;
              hold_cnt_q <= HoldReload;
            end else if (hold_cnt_q != '0) begin
              hold_cnt_q <= hold_cnt_q - HoldW'(1);
            end else begin
              state_q <= StDecay;
            end
          end
          StDecay: begin
            if (result >= decay_floor) begin
              peak_q     <= result;
              hold_cnt_q <= HoldReload;
              state_q    <= StHold;
            end else begin
              peak_q <= decay_floor;
            end
          end
          default: state_q <= StHold;
        endcase
      end
    end
  end

  assign peak_o    = peak_q;
  assign win_max_o = win_max_q;
  assign clip_o    = clip_q;

endmodule

// File: rtl/peak_meter.sv
// Multi-channel windowed peak meter: shared window counter and update strobe,
// with one peak_meter_chan per channel.
module peak_meter
  import peak_meter_pkg::*;
#(
  parameter int unsigned DataW       = 16,
  parameter int unsigned Channels    = 2,
  parameter int unsigned WinLog2     = 9,
  parameter int unsigned HoldWindows = 4,
  parameter int unsigned DecayStep   = 1,
  parameter bit          SignedIn    = 1'b1,
  localparam int unsigned MagW       = mag_width(DataW, SignedIn)
) (
  input  logic                     dclk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     din_valid_i,
  input  logic [Channels*DataW-1:0] din_i,
  output logic [Channels*MagW-1:0]  peak_out_o,
  output logic [Channels*MagW-1:0]  win_max_o,
  output logic [Channels-1:0]       clip_o,
  output logic                      peak_valid_o
);

  logic [WinLog2-1:0] win_cnt_q;
  logic               peak_valid_q;
  logic               win_final;

  assign win_final = &win_cnt_q;

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      win_cnt_q    <= '0;
      peak_valid_q <= 1'b0;
    end else if (clear_i) begin
      win_cnt_q    <= '0;
      peak_valid_q <= 1'b0;
    end else begin
      peak_valid_q <= din_valid_i & win_final;
      if (din_valid_i) win_cnt_q <= win_cnt_q + WinLog2'(1);
    end
  end

  assign peak_valid_o = peak_valid_q;

  for (genvar c = 0; c < Channels; c++) begin : g_chan
    peak_meter_chan #(
      .DataW       (DataW),
      .HoldWindows (HoldWindows),
      .DecayStep   (DecayStep),
      .SignedIn    (SignedIn)
    ) u_chan (
      .dclk      (dclk),
      .rst       (rst),
      .clear_i   (clear_i),
      .valid_i   (din_valid_i),
      .final_i   (win_final),
      .din_i     (din_i[c*DataW +: DataW]),
      .peak_o    (peak_out_o[c*MagW +: MagW]),
      .win_max_o (win_max_o[c*MagW +: MagW]),
      .clip_o    (clip_o[c])
    );
  end

endmodule
